// File: rtl/gshare_branch_predictor_if.sv
// gshare_branch_predictor_if
// Fetch/execute side bundle for the gshare direction + BTB target predictor.
//   Lookup (IF) : pc, pred_req            -> pred_hit, pred_taken, pred_target, pred_ghr
//   Training(EX): update_en, update_pc, update_taken, update_target,
//                 update_ghr, update_mispredict
// master = pipeline (drives lookups and training), slave = predictor.
interface gshare_branch_predictor_if #(
  parameter int GHR_W = 8
);
  logic [31:0]      pc;
  logic             pred_req;
  logic             pred_hit;
  logic             pred_taken;
  logic [31:0]      pred_target;
  logic [GHR_W-1:0] pred_ghr;
  logic             update_en;
  logic [31:0]      update_pc;
  logic             update_taken;
  logic [31:0]      update_target;
  logic [GHR_W-1:0] update_ghr;
  logic             update_mispredict;

  modport master (
    output pc, pred_req,
    output update_en, update_pc, update_taken, update_target, update_ghr, update_mispredict,
    input  pred_hit, pred_taken, pred_target, pred_ghr
  );

  modport slave (
    input  pc, pred_req,
    input  update_en, update_pc, update_taken, update_target, update_ghr, update_mispredict,
    output pred_hit, pred_taken, pred_target, pred_ghr
  );
endinterface

// File: rtl/gshare_branch_predictor.sv
// gshare_branch_predictor
// Combinational direction/target prediction for the RV32IC fetch stage.
//   clk, rst_n : clock, asynchronous active-low reset
//   bp (slave) : lookup on bp.pc, training and GHR recovery from EX
// Direction: 2-bit counters indexed by pc[BI:1] ^ GHR (gshare).
// Target   : 2-way set-associative BTB, halfword granular, one LRU bit per set.
module gshare_branch_predictor #(
  parameter int BHT_ENTRIES = 512,
  parameter int BTB_SETS    = 32,
  parameter int GHR_W       = 8
) (
  input logic                      clk,
  input logic                      rst_n,
  gshare_branch_predictor_if.slave bp
);
  localparam int BI = $clog2(BHT_ENTRIES);
  localparam int SI = $clog2(BTB_SETS);
  localparam int TW = 31 - SI;

  logic [1:0]    bht        [BHT_ENTRIES];
  logic          btb_valid  [2][BTB_SETS];
  logic [TW-1:0] btb_tag    [2][BTB_SETS];
  logic [31:0]   btb_target [2][BTB_SETS];
  logic          btb_lru    [BTB_SETS];

  logic [GHR_W-1:0] ghr, ghr_next, spec_shift, rec_shift;
  logic [BI-1:0]    ghr_ext, ughr_ext, pred_idx, upd_idx;
  logic [SI-1:0]    pred_set, upd_set;
  logic [TW-1:0]    pred_tag, upd_tag;
  logic             way0_hit, way1_hit, upd_hit0, upd_hit1, victim;
  logic [1:0]       upd_ctr_cur, upd_ctr_next;
  logic [31:0]      alloc_target;
  logic             unused_bits;

  // Bit 0 of a halfword-aligned PC carries no information.
  assign unused_bits = bp.pc[0] ^ bp.update_pc[0];

  // History is zero-extended into the counter index width.
  always_comb begin
    ghr_ext                = '0;
    ghr_ext[GHR_W-1:0]     = ghr;
    ughr_ext               = '0;
    ughr_ext[GHR_W-1:0]    = bp.update_ghr;
  end

  // Lookup side: purely combinational, never touches LRU.
  always_comb begin
    pred_idx = bp.pc[BI:1] ^ ghr_ext;
    pred_set = bp.pc[SI:1];
    pred_tag = bp.pc[31:SI+1];
    way0_hit = btb_valid[0][pred_set] && (btb_tag[0][pred_set] == pred_tag);
    way1_hit = btb_valid[1][pred_set] && (btb_tag[1][pred_set] == pred_tag);
    bp.pred_hit    = way0_hit | way1_hit;
    bp.pred_taken  = (way0_hit | way1_hit) & bht[pred_idx][1];
    bp.pred_ghr    = ghr;
    if (way0_hit)
      bp.pred_target = btb_target[0][pred_set];
    else if (way1_hit)
      bp.pred_target = btb_target[1][pred_set];
    else
      bp.pred_target = '0;
  end

  // Training side decode; the victim is the first invalid way, else the LRU way.
  always_comb begin
    upd_idx      = bp.update_pc[BI:1] ^ ughr_ext;
    upd_set      = bp.update_pc[SI:1];
    upd_tag      = bp.update_pc[31:SI+1];
    upd_hit0     = btb_valid[0][upd_set] && (btb_tag[0][upd_set] == upd_tag);
    upd_hit1     = btb_valid[1][upd_set] && (btb_tag[1][upd_set] == upd_tag);
    upd_ctr_cur  = bht[upd_idx];
    upd_ctr_next = upd_ctr_cur;
    if (bp.update_taken && upd_ctr_cur != 2'b11)
      upd_ctr_next = upd_ctr_cur + 2'd1;
    else if (!bp.update_taken && upd_ctr_cur != 2'b00)
      upd_ctr_next = upd_ctr_cur - 2'd1;
    if (!btb_valid[0][upd_set])
      victim = 1'b0;
    else if (!btb_valid[1][upd_set])
      victim = 1'b1;
    else
      victim = btb_lru[upd_set];
    alloc_target = bp.update_taken ? bp.update_target : bp.update_pc + 32'd4;
  end

  // GHR_W == 1 keeps only the newest outcome.
  generate
    if (GHR_W == 1) begin : g_ghr_one
      assign spec_shift = bp.pred_taken;
      assign rec_shift  = bp.update_taken;
    end else begin : g_ghr_wide
      assign spec_shift = {ghr[GHR_W-2:0], bp.pred_taken};
      assign rec_shift  = {bp.update_ghr[GHR_W-2:0], bp.update_taken};
    end
  endgenerate

  // Misprediction recovery overrides a same-cycle speculative shift.
  always_comb begin
    ghr_next = ghr;
    if (bp.update_en && bp.update_mispredict)
      ghr_next = rec_shift;
    else if (bp.pred_req && bp.pred_hit)
      ghr_next = spec_shift;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ghr <= '0;
    else
      ghr <= ghr_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++)
        bht[i] <= 2'b01;
    end else if (bp.update_en) begin
      bht[upd_idx] <= upd_ctr_next;
    end
  end

  // A tag hit refreshes the target only on taken; a miss allocates into the victim.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < BTB_SETS; s++) begin
        for (int w = 0; w < 2; w++) begin
          btb_valid[w][s]  <= 1'b0;
          btb_tag[w][s]    <= '0;
          btb_target[w][s] <= '0;
        end
        btb_lru[s] <= 1'b0;
      end
    end else if (bp.update_en) begin
      if (upd_hit0) begin
        if (bp.update_taken)
          btb_target[0][upd_set] <= bp.update_target;
        btb_lru[upd_set] <= 1'b1;
      end else if (upd_hit1) begin
        if (bp.update_taken)
          btb_target[1][upd_set] <= bp.update_target;
        btb_lru[upd_set] <= 1'b0;
      end else begin
        btb_valid[victim][upd_set]  <= 1'b1;
        btb_tag[victim][upd_set]    <= upd_tag;
        btb_target[victim][upd_set] <= alloc_target;
        btb_lru[upd_set]            <= ~victim;
      end
    end
  end
endmodule

// File: tb/tb_gshare_branch_predictor.sv
// tb_gshare_branch_predictor
// Directed bench for gshare_branch_predictor (default parameters 512/32/8).
// Expected lookups are queued by applyStimulus and popped by checkOutput.
module tb_gshare_branch_predictor;
  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  gshare_branch_predictor_if #(.GHR_W(8)) bp ();

  gshare_branch_predictor #(
    .BHT_ENTRIES(512),
    .BTB_SETS   (32),
    .GHR_W      (8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bp   (bp)
  );

  typedef struct {
    string       tag;
    logic        hit;
    logic        taken;
    logic [31:0] target;
    logic [7:0]  ghr;
  } exp_t;

  exp_t scoreboard[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a lookup PC and queue what the predictor must answer.
  task automatic applyStimulus(input string tag, input logic [31:0] pc, input logic hit,
                               input logic taken, input logic [31:0] target, input logic [7:0] ghr);
    exp_t e;
    bp.pc    = pc;
    e.tag    = tag;
    e.hit    = hit;
    e.taken  = taken;
    e.target = target;
    e.ghr    = ghr;
    scoreboard.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    #1;
    e = scoreboard.pop_front();
    vectors++;
    assert (bp.pred_hit === e.hit) else begin
      miscompares++;
      $error("[TB] FAIL %s.hit got %b expected %b", e.tag, bp.pred_hit, e.hit);
    end
    vectors++;
    assert (bp.pred_taken === e.taken) else begin
      miscompares++;
      $error("[TB] FAIL %s.taken got %b expected %b", e.tag, bp.pred_taken, e.taken);
    end
    vectors++;
    assert (bp.pred_target === e.target) else begin
      miscompares++;
      $error("[TB] FAIL %s.target got %h expected %h", e.tag, bp.pred_target, e.target);
    end
    vectors++;
    assert (bp.pred_ghr === e.ghr) else begin
      miscompares++;
      $error("[TB] FAIL %s.ghr got %h expected %h", e.tag, bp.pred_ghr, e.ghr);
    end
  endtask

  task automatic probe(input string tag, input logic [31:0] pc, input logic hit,
                       input logic taken, input logic [31:0] target, input logic [7:0] ghr);
    applyStimulus(tag, pc, hit, taken, target, ghr);
    checkOutput();
  endtask

  // One cycle of EX training, then training inputs drop again.
  task automatic doUpdate(input logic [31:0] pc, input logic taken, input logic [31:0] target,
                          input logic [7:0] ghr, input logic mispredict);
    bp.update_en         = 1'b1;
    bp.update_pc         = pc;
    bp.update_taken      = taken;
    bp.update_target     = target;
    bp.update_ghr        = ghr;
    bp.update_mispredict = mispredict;
    tick();
    bp.update_en         = 1'b0;
    bp.update_mispredict = 1'b0;
  endtask

  initial begin
    vectors              = 0;
    miscompares          = 0;
    rst_n                = 1'b0;
    bp.pc                = 32'h100;
    bp.pred_req          = 1'b0;
    bp.update_en         = 1'b0;
    bp.update_pc         = '0;
    bp.update_taken      = 1'b0;
    bp.update_target     = '0;
    bp.update_ghr        = '0;
    bp.update_mispredict = 1'b0;

    // Reset state
    probe("rst", 32'h100, 0, 0, 32'h0, 8'h00);
    tick();
    rst_n = 1'b1;
    tick();
    probe("post_rst", 32'h100, 0, 0, 32'h0, 8'h00);

    // Compressed branch at 0x102 trained taken twice
    doUpdate(32'h102, 1, 32'h080, 8'h00, 0);
    doUpdate(32'h102, 1, 32'h080, 8'h00, 0);
    probe("c_hit", 32'h102, 1, 1, 32'h080, 8'h00);
    probe("c_nbr", 32'h100, 0, 0, 32'h0, 8'h00);

    // Three tags in BTB set 0: third evicts the first
    doUpdate(32'h100, 1, 32'h1000, 8'h00, 0);
    doUpdate(32'h140, 1, 32'h2000, 8'h00, 0);
    doUpdate(32'h180, 1, 32'h3000, 8'h00, 0);
    probe("evict_a", 32'h100, 0, 0, 32'h0, 8'h00);
    probe("keep_b", 32'h140, 1, 1, 32'h2000, 8'h00);
    probe("new_c", 32'h180, 1, 1, 32'h3000, 8'h00);
    // LRU now names way 1, so a fourth tag replaces 0x140
    doUpdate(32'h1C0, 1, 32'h4000, 8'h00, 0);
    probe("lru_d", 32'h1C0, 1, 1, 32'h4000, 8'h00);
    probe("lru_b", 32'h140, 0, 0, 32'h0, 8'h00);
    probe("lru_c", 32'h180, 1, 1, 32'h3000, 8'h00);

    // Warm the 0x102 counters seen with histories 1 and 3
    doUpdate(32'h102, 1, 32'h080, 8'h01, 0);
    doUpdate(32'h102, 1, 32'h080, 8'h03, 0);

    // Speculative history shift over three hitting taken fetches
    bp.pred_req = 1'b1;
    probe("spec0", 32'h102, 1, 1, 32'h080, 8'h00);
    tick();
    probe("spec1", 32'h102, 1, 1, 32'h080, 8'h01);
    tick();
    probe("spec2", 32'h102, 1, 1, 32'h080, 8'h03);
    tick();
    bp.pred_req = 1'b0;
    probe("spec3", 32'h102, 1, 0, 32'h080, 8'h07);

    // Recovery wins over a same-cycle speculative shift
    bp.pred_req = 1'b1;
    doUpdate(32'h310, 0, 32'h0, 8'h01, 1);
    bp.pred_req = 1'b0;
    probe("recov", 32'h102, 1, 0, 32'h080, 8'h02);
    probe("nt_alloc", 32'h310, 1, 0, 32'h314, 8'h02);
    doUpdate(32'h310, 0, 32'h0, 8'h00, 1);
    probe("recov0", 32'h310, 1, 0, 32'h314, 8'h00);

    // Alternating T,N at 0x200 under two histories
    doUpdate(32'h200, 1, 32'h400, 8'h02, 0);
    doUpdate(32'h200, 0, 32'h0, 8'h05, 0);
    doUpdate(32'h200, 1, 32'h400, 8'h02, 0);
    doUpdate(32'h200, 0, 32'h0, 8'h05, 0);
    doUpdate(32'h310, 0, 32'h314, 8'h01, 1);
    probe("alt_t", 32'h200, 1, 1, 32'h400, 8'h02);
    doUpdate(32'h310, 1, 32'h314, 8'h02, 1);
    probe("alt_n", 32'h200, 1, 0, 32'h400, 8'h05);
    probe("alt_ev", 32'h180, 0, 0, 32'h0, 8'h05);
    probe("alt_d", 32'h1C0, 1, 0, 32'h4000, 8'h05);

    // Counter saturation at 11, then decrements
    for (int i = 0; i < 5; i++)
      doUpdate(32'h64C, 1, 32'h700, 8'h05, 0);
    probe("sat_hi", 32'h64C, 1, 1, 32'h700, 8'h05);
    doUpdate(32'h64C, 0, 32'h0, 8'h05, 0);
    probe("sat_dec1", 32'h64C, 1, 1, 32'h700, 8'h05);
    doUpdate(32'h64C, 0, 32'h0, 8'h05, 0);
    probe("sat_dec2", 32'h64C, 1, 0, 32'h700, 8'h05);

    // Same-cycle lookup and update: old contents until the edge
    bp.update_en         = 1'b1;
    bp.update_pc         = 32'h64C;
    bp.update_taken      = 1'b1;
    bp.update_target     = 32'h700;
    bp.update_ghr        = 8'h05;
    bp.update_mispredict = 1'b0;
    probe("bypass_pre", 32'h64C, 1, 0, 32'h700, 8'h05);
    tick();
    bp.update_en = 1'b0;
    probe("bypass_post", 32'h64C, 1, 1, 32'h700, 8'h05);

    // Asynchronous reset in mid-cycle wipes everything
    #2;
    rst_n = 1'b0;
    probe("mid_rst", 32'h102, 0, 0, 32'h0, 8'h00);
    tick();
    rst_n = 1'b1;
    tick();
    probe("after_rst", 32'h64C, 0, 0, 32'h0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
